// File: rtl/cache_pkg.sv
// Shared definitions for the cache line fill/writeback controllers.
package cache_pkg;

  localparam logic [1:0] FETCH_NOP     = 2'b00;
  localparam logic [1:0] FETCH_LINE    = 2'b01;
  localparam logic [1:0] FETCH_WB_LINE = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WB_RD,
    WB_WAIT,
    WB_SEND,
    RD_REQ,
    RD_DATA,
    DONE
  } fill_state_e;

endpackage

// File: rtl/line_fill_engine_if.sv
// Bundles the fetch, cache-data and external-bus signals of the line fill engine.
// The master modport is the engine itself; slave is its surrounding environment.
interface line_fill_engine_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LIST_DEPTH = 4,
  parameter int LIST_WIDTH = 32
);
  localparam int TW = $clog2(LIST_DEPTH);
  localparam int WW = $clog2(LIST_WIDTH);

  logic                  fetch_req;
  logic                  fetch_gnt;
  logic [1:0]            fetch_cmd;
  logic [TW-1:0]         fetch_tag;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic [ADDR_WIDTH-1:0] fetch_addr_pre;
  logic                  fetch_done;

  logic [TW+WW-1:0]      mem_raddr;
  logic                  mem_ren;
  logic                  mem_rready;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_rdata_valid;
  logic [TW+WW-1:0]      mem_waddr;
  logic                  mem_wen;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic                  ext_rd_req;
  logic                  ext_rd_gnt;
  logic [ADDR_WIDTH-1:0] ext_rd_addr;
  logic [DATA_WIDTH-1:0] ext_rd_data;
  logic                  ext_rd_data_valid;
  logic                  ext_wr_valid;
  logic                  ext_wr_ready;
  logic [ADDR_WIDTH-1:0] ext_wr_addr;
  logic [DATA_WIDTH-1:0] ext_wr_data;

  modport master (
    input  fetch_req, fetch_cmd, fetch_tag, fetch_addr, fetch_addr_pre,
    output fetch_gnt, fetch_done,
    output mem_raddr, mem_ren, mem_waddr, mem_wen, mem_wdata,
    input  mem_rready, mem_rdata, mem_rdata_valid,
    output ext_rd_req, ext_rd_addr, ext_wr_valid, ext_wr_addr, ext_wr_data,
    input  ext_rd_gnt, ext_rd_data, ext_rd_data_valid, ext_wr_ready
  );

  modport slave (
    output fetch_req, fetch_cmd, fetch_tag, fetch_addr, fetch_addr_pre,
    input  fetch_gnt, fetch_done,
    input  mem_raddr, mem_ren, mem_waddr, mem_wen, mem_wdata,
    output mem_rready, mem_rdata, mem_rdata_valid,
    input  ext_rd_req, ext_rd_addr, ext_wr_valid, ext_wr_addr, ext_wr_data,
    output ext_rd_gnt, ext_rd_data, ext_rd_data_valid, ext_wr_ready
  );

endinterface

// File: rtl/line_fill_engine.sv
// Cache line fill engine: optionally writes a victim line back to external
// memory word by word, then streams a new line from external memory into the
// cache data array, and pulses fetch_done once the line is complete.
module line_fill_engine
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LIST_DEPTH = 4,
  parameter int LIST_WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  line_fill_engine_if.master bus
);

  localparam int TW         = $clog2(LIST_DEPTH);
  localparam int WW         = $clog2(LIST_WIDTH);
  localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam logic [WW-1:0] LAST_WORD = WW'(LIST_WIDTH - 1);

  fill_state_e           r_state;
  logic [WW-1:0]         r_cnt;
  logic [TW-1:0]         r_tag;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_addr_pre;
  logic [DATA_WIDTH-1:0] r_wb_data;

  logic                  w_grant;
  logic                  w_last;
  logic                  w_beat;
  logic [TW+WW-1:0]      w_word_idx;
  logic [ADDR_WIDTH-1:0] w_wb_offset;

  // The grant is gated by rst_n so that nothing is acknowledged while held in reset.
  assign w_grant     = rst_n && bus.fetch_req && (r_state == IDLE);
  assign w_last      = (r_cnt == LAST_WORD);
  assign w_beat      = (r_state == RD_DATA) && bus.ext_rd_data_valid;
  assign w_word_idx  = {r_tag, r_cnt};
  assign w_wb_offset = ADDR_WIDTH'(r_cnt) << BYTE_SHIFT;

  // Sequencer: captures the request on grant, walks the victim words out, then the fill beats in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_tag      <= '0;
      r_addr     <= '0;
      r_addr_pre <= '0;
      r_wb_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_tag      <= bus.fetch_tag;
            r_addr     <= bus.fetch_addr;
            r_addr_pre <= bus.fetch_addr_pre;
            r_cnt      <= '0;
            case (bus.fetch_cmd)
              FETCH_WB_LINE: r_state <= WB_RD;
              FETCH_LINE:    r_state <= RD_REQ;
              default:       r_state <= DONE;
            endcase
          end
        end
        WB_RD: begin
          if (bus.mem_rready) r_state <= WB_WAIT;
        end
        WB_WAIT: begin
          if (bus.mem_rdata_valid) begin
            r_wb_data <= bus.mem_rdata;
            r_state   <= WB_SEND;
          end
        end
        WB_SEND: begin
          if (bus.ext_wr_ready) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= RD_REQ;
            end else begin
              r_state <= WB_RD;
            end
          end
        end
        RD_REQ: begin
          if (bus.ext_rd_gnt) r_state <= RD_DATA;
        end
        RD_DATA: begin
          if (w_beat) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Strobes decode the registered state; address/data buses are forced to zero while their strobe is low.
  assign bus.fetch_gnt    = w_grant;
  assign bus.fetch_done   = (r_state == DONE);
  assign bus.mem_ren      = (r_state == WB_RD);
  assign bus.mem_raddr    = (r_state == WB_RD) ? w_word_idx : '0;
  assign bus.mem_wen      = w_beat;
  assign bus.mem_waddr    = w_beat ? w_word_idx : '0;
  assign bus.mem_wdata    = w_beat ? bus.ext_rd_data : '0;
  assign bus.ext_rd_req   = (r_state == RD_REQ);
  assign bus.ext_rd_addr  = (r_state == RD_REQ) ? r_addr : '0;
  assign bus.ext_wr_valid = (r_state == WB_SEND);
  assign bus.ext_wr_addr  = (r_state == WB_SEND) ? (r_addr_pre + w_wb_offset) : '0;
  assign bus.ext_wr_data  = (r_state == WB_SEND) ? r_wb_data : '0;

endmodule
